decode_queue: RTL and testbench

- Buffered, parametrised instruction-decode stage between instruction fetch and issue/dispatch.
- Accepts raw RV32I instructions with their PC over a valid/ready handshake and decodes them at enqueue.
- Holds decoded records in a DEPTH-entry circular FIFO and presents the head record downstream over a valid/ready handshake.
- Adds flush, occupancy reporting and illegal-instruction flagging, none of which the previous combinational decoder had.

---
 rtl/decode_queue_pkg.sv | 44 ++++
 rtl/decode_queue_if.sv | 47 ++++
 rtl/decode_queue_inst_decode_core.sv | 119 +++++++++++
 rtl/decode_queue.sv | 128 ++++++++++++
 tb/tb_decode_queue.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared constants and types for the decode queue.
//   - RV32I major opcodes used by the decoder
//   - internal op encoding (ADD..LUI), 5 bits wide
//   - decoded-record layout stored per FIFO entry
// Optional feature macro BR_TARGET_EN has no effect on this file.
package decode_queue_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned OP_ENC_W = 5;

  typedef enum logic [6:0] {
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111,
    OPC_JAL   = 7'b1101111,
    OPC_JALR  = 7'b1100111,
    OPC_BR    = 7'b1100011,
    OPC_LD    = 7'b0000011,
    OPC_ST    = 7'b0100011,
    OPC_IMM   = 7'b0010011,
    OPC_BIN   = 7'b0110011
  } opcode_e;

  typedef enum logic [OP_ENC_W-1:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH,
    OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL,
    OP_JALR, OP_AUIPC, OP_LUI
  } op_e;

  typedef struct packed {
    op_e              op;
    logic             branch;
    logic             ls;
    logic             use_imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } dec_rec_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side handshake bundle.
//   in_*  : fetch offers an instruction + PC (valid/ready)
//   out_* : decoded head record towards issue (valid/ready)
//   master = producer/consumer side, slave = decode_queue side.
// With BR_TARGET_EN defined, out_target carries the per-entry branch target.
interface decode_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [ADDR_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic              out_branch;
  logic              out_ls;
  logic              out_use_imm;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [31:0]       out_imm;
  logic [ADDR_W-1:0] out_pc;
  logic              out_illegal;
`ifdef BR_TARGET_EN
  logic [ADDR_W-1:0] out_target;
`endif

  modport master (
`ifdef BR_TARGET_EN
    input  out_target,
`endif
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_branch, out_ls, out_use_imm,
           out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal
  );

  modport slave (
`ifdef BR_TARGET_EN
    output out_target,
`endif
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_branch, out_ls, out_use_imm,
           out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_queue_inst_decode_core.sv
// inst_decode_core: purely combinational RV32I instruction -> decoded record.
//   inst : raw 32-bit instruction
//   rec  : op, branch/ls/use_imm flags, register indices, immediate, illegal
// Unsupported encodings yield illegal=1 with a neutral ADD/no-imm record.
// Optional feature macro BR_TARGET_EN has no effect on this file.
module inst_decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output dec_rec_t    rec
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign shamt = {27'b0, inst[24:20]};

  always_comb begin
    rec         = '0;
    rec.op      = OP_ADD;
    rec.rd      = inst[11:7];
    rec.rs1     = inst[19:15];
    rec.rs2     = inst[24:20];
    rec.use_imm = 1'b1;
    case (inst[6:0])
      OPC_LUI:   begin rec.op = OP_LUI;   rec.imm = imm_u; end
      OPC_AUIPC: begin rec.op = OP_AUIPC; rec.imm = imm_u; end
      OPC_JAL:   begin rec.op = OP_JAL; rec.branch = 1'b1; rec.imm = imm_j; end
      OPC_JALR: begin
        rec.op = OP_JALR; rec.branch = 1'b1; rec.imm = imm_i;
        rec.illegal = (f3 != 3'b000);
      end
      OPC_BR: begin
        rec.branch = 1'b1; rec.imm = imm_b;
        case (f3)
          3'b000:  rec.op = OP_BEQ;
          3'b001:  rec.op = OP_BNE;
          3'b100:  rec.op = OP_BLT;
          3'b101:  rec.op = OP_BGE;
          3'b110:  rec.op = OP_BLTU;
          3'b111:  rec.op = OP_BGEU;
          default: rec.illegal = 1'b1;
        endcase
      end
      OPC_LD: begin
        rec.ls = 1'b1; rec.imm = imm_i;
        case (f3)
          3'b000:  rec.op = OP_LB;
          3'b001:  rec.op = OP_LH;
          3'b010:  rec.op = OP_LW;
          3'b100:  rec.op = OP_LBU;
          3'b101:  rec.op = OP_LHU;
          default: rec.illegal = 1'b1;
        endcase
      end
      OPC_ST: begin
        rec.ls = 1'b1; rec.imm = imm_s;
        case (f3)
          3'b000:  rec.op = OP_SB;
          3'b001:  rec.op = OP_SH;
          3'b010:  rec.op = OP_SW;
          default: rec.illegal = 1'b1;
        endcase
      end
      OPC_IMM: begin
        rec.imm = imm_i;
        case (f3)
          3'b000: rec.op = OP_ADD;
          3'b001: begin rec.op = OP_SLL; rec.imm = shamt; end
          3'b010: rec.op = OP_SLT;
          3'b011: rec.op = OP_SLTU;
          3'b100: rec.op = OP_XOR;
          3'b101: begin rec.op = inst[30] ? OP_SRA : OP_SRL; rec.imm = shamt; end
          3'b110: rec.op = OP_OR;
          default: rec.op = OP_AND;
        endcase
      end
      OPC_BIN: begin
        rec.use_imm = 1'b0;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  rec.op = OP_ADD;
            3'b001:  rec.op = OP_SLL;
            3'b010:  rec.op = OP_SLT;
            3'b011:  rec.op = OP_SLTU;
            3'b100:  rec.op = OP_XOR;
            3'b101:  rec.op = OP_SRL;
            3'b110:  rec.op = OP_OR;
            default: rec.op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          rec.op = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          rec.op = OP_SRA;
        end else begin
          rec.illegal = 1'b1;
        end
      end
      default: rec.illegal = 1'b1;
    endcase
    // Illegal entries still travel down the queue, but as an inert ADD.
    if (rec.illegal) begin
      rec.op      = OP_ADD;
      rec.use_imm = 1'b0;
      rec.branch  = 1'b0;
      rec.ls      = 1'b0;
      rec.imm     = '0;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage, DEPTH-entry circular FIFO.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   flush          : synchronous discard of all entries (beats push/pop)
//   bus (slave)    : in_* fetch handshake, out_* head-record handshake
//   count          : current occupancy
// Instructions are decoded at enqueue; head fields come straight from storage.
// Define BR_TARGET_EN to add out_target (pc+imm for BRANCH/JAL, else 0).
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 5
)(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush,
  decode_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  dec_rec_t          dec;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  dec_rec_t          rec_q [DEPTH];
  dec_rec_t          rec_d [DEPTH];
  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [ADDR_W-1:0] pc_d  [DEPTH];
  logic              in_ready, out_valid, push, pop;
`ifdef BR_TARGET_EN
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] tgt_q [DEPTH];
  logic [ADDR_W-1:0] tgt_d [DEPTH];
`endif

  inst_decode_core u_decode (
    .inst (bus.in_inst),
    .rec  (dec)
  );

`ifdef BR_TARGET_EN
  // JALR is a branch but its target depends on rs1, so it stores 0.
  assign tgt = (dec.branch && dec.op != OP_JALR)
             ? bus.in_pc + ADDR_W'($signed(dec.imm)) : '0;
`endif

  // Full blocks a push even when a pop happens in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rec_d   = rec_q;
    pc_d    = pc_q;
`ifdef BR_TARGET_EN
    tgt_d   = tgt_q;
`endif
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        rec_d[tail_q] = dec;
        pc_d[tail_q]  = bus.in_pc;
`ifdef BR_TARGET_EN
        tgt_d[tail_q] = tgt;
`endif
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rec_q[i] <= '0;
        pc_q[i]  <= '0;
`ifdef BR_TARGET_EN
        tgt_q[i] <= '0;
`endif
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rec_q   <= rec_d;
      pc_q    <= pc_d;
`ifdef BR_TARGET_EN
      tgt_q   <= tgt_d;
`endif
    end
  end

  assign count           = count_q;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_op      = OP_W'(rec_q[head_q].op);
  assign bus.out_branch  = rec_q[head_q].branch;
  assign bus.out_ls      = rec_q[head_q].ls;
  assign bus.out_use_imm = rec_q[head_q].use_imm;
  assign bus.out_rd      = rec_q[head_q].rd;
  assign bus.out_rs1     = rec_q[head_q].rs1;
  assign bus.out_rs2     = rec_q[head_q].rs2;
  assign bus.out_imm     = rec_q[head_q].imm;
  assign bus.out_illegal = rec_q[head_q].illegal;
  assign bus.out_pc      = pc_q[head_q];
`ifdef BR_TARGET_EN
  assign bus.out_target  = tgt_q[head_q];
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed + randomized checks of decode_queue against a
// queue-based reference model with an arithmetic decoder.
// Honours BR_TARGET_EN when defined.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 5;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  decode_queue_if #(.ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (flush),
    .bus    (bus),
    .count  (count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          op;
    bit          branch, ls, use_imm, illegal;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc, target;
  } exp_t;

  exp_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder: immediates rebuilt by arithmetic, ops via lookup tables.
  function automatic exp_t model_decode(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    int opc = int'(i[6:0]);
    int f3  = int'(i[14:12]);
    int f7  = int'(i[31:25]);
    int sgn = ($signed(i) >>> 31);
    int alu_map[8] = '{int'(OP_ADD), int'(OP_SLL), int'(OP_SLT), int'(OP_SLTU),
                       int'(OP_XOR), int'(OP_SRL), int'(OP_OR), int'(OP_AND)};
    int ld_map[8]  = '{int'(OP_LB), int'(OP_LH), int'(OP_LW), -1,
                       int'(OP_LBU), int'(OP_LHU), -1, -1};
    int st_map[8]  = '{int'(OP_SB), int'(OP_SH), int'(OP_SW), -1, -1, -1, -1, -1};
    int br_map[8]  = '{int'(OP_BEQ), int'(OP_BNE), -1, -1, int'(OP_BLT),
                       int'(OP_BGE), int'(OP_BLTU), int'(OP_BGEU)};
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    imm_i = $signed(i) >>> 20;
    imm_s = sgn * 4096 + int'(i[31:25]) * 32 + int'(i[11:7]);
    imm_b = sgn * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    imm_j = sgn * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    imm_u = i & 32'hFFFF_F000;
    e = '{default: 0};
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.pc = pc;
    e.use_imm = 1;
    case (opc)
      'h37: begin e.op = int'(OP_LUI);   e.imm = imm_u; end
      'h17: begin e.op = int'(OP_AUIPC); e.imm = imm_u; end
      'h6F: begin e.op = int'(OP_JAL);   e.imm = imm_j; e.branch = 1; end
      'h67: begin e.op = (f3 == 0) ? int'(OP_JALR) : -1; e.imm = imm_i; e.branch = 1; end
      'h63: begin e.op = br_map[f3]; e.imm = imm_b; e.branch = 1; end
      'h03: begin e.op = ld_map[f3]; e.imm = imm_i; e.ls = 1; end
      'h23: begin e.op = st_map[f3]; e.imm = imm_s; e.ls = 1; end
      'h13: begin
        e.op  = alu_map[f3];
        e.imm = imm_i;
        if (f3 == 1 || f3 == 5) e.imm = int'(i[24:20]);
        if (f3 == 5 && i[30]) e.op = int'(OP_SRA);
      end
      'h33: begin
        e.use_imm = 0;
        if (f7 == 0)                 e.op = alu_map[f3];
        else if (f7 == 32 && f3 == 0) e.op = int'(OP_SUB);
        else if (f7 == 32 && f3 == 5) e.op = int'(OP_SRA);
        else                          e.op = -1;
      end
      default: e.op = -1;
    endcase
    if (e.op < 0) begin
      e.illegal = 1; e.op = int'(OP_ADD); e.use_imm = 0;
      e.branch = 0; e.ls = 0; e.imm = 0;
    end
    if (!e.illegal && (opc == 'h63 || opc == 'h6F)) e.target = pc + e.imm;
    return e;
  endfunction

  task automatic compare_outputs(string tag);
    check_eq({tag, ".count"}, 64'(count), 64'(mq.size()));
    check_eq({tag, ".in_ready"}, 64'(bus.in_ready), 64'(mq.size() != DEPTH));
    check_eq({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq({tag, ".op"}, 64'(bus.out_op), 64'(mq[0].op));
      check_eq({tag, ".branch"}, 64'(bus.out_branch), 64'(mq[0].branch));
      check_eq({tag, ".ls"}, 64'(bus.out_ls), 64'(mq[0].ls));
      check_eq({tag, ".use_imm"}, 64'(bus.out_use_imm), 64'(mq[0].use_imm));
      check_eq({tag, ".rd"}, 64'(bus.out_rd), 64'(mq[0].rd));
      check_eq({tag, ".rs1"}, 64'(bus.out_rs1), 64'(mq[0].rs1));
      check_eq({tag, ".rs2"}, 64'(bus.out_rs2), 64'(mq[0].rs2));
      check_eq({tag, ".imm"}, 64'(bus.out_imm), 64'(mq[0].imm));
      check_eq({tag, ".pc"}, 64'(bus.out_pc), 64'(mq[0].pc));
      check_eq({tag, ".illegal"}, 64'(bus.out_illegal), 64'(mq[0].illegal));
`ifdef BR_TARGET_EN
      check_eq({tag, ".target"}, 64'(bus.out_target), 64'(mq[0].target));
`endif
    end
  endtask

  // One clock: drive inputs, advance the model, then sample 1 time unit later.
  task automatic cycle(string tag, bit v, logic [31:0] inst, logic [31:0] pc,
                       bit rdy, bit fl);
    bit do_push, do_pop;
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = rdy && (mq.size() > 0) && !fl;
    @(posedge clk_in);
    #1;
    if (fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(model_decode(inst, pc));
    end
    compare_outputs(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  opcs[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    int unsigned k;
    r = $urandom();
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = opcs[k];
    if (k == 8 && $urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    rst_in = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #12;
    check_eq("rst.count", 64'(count), 64'd0);
    check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst.out_imm", 64'(bus.out_imm), 64'd0);
    check_eq("rst.out_pc", 64'(bus.out_pc), 64'd0);
    rst_in = 1'b0;

    // addi x1,x0,-1
    cycle("addi", 1, 32'hFFF0_0093, 32'h0, 0, 0);
    check_eq("addi.valid", 64'(bus.out_valid), 64'd1);
    check_eq("addi.op", 64'(bus.out_op), 64'(OP_ADD));
    check_eq("addi.use_imm", 64'(bus.out_use_imm), 64'd1);
    check_eq("addi.rd", 64'(bus.out_rd), 64'd1);
    check_eq("addi.imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
    check_eq("addi.illegal", 64'(bus.out_illegal), 64'd0);
    cycle("drain0", 0, 32'h0, 32'h0, 1, 0);

    // sub then beq, in order
    cycle("sub", 1, 32'h4020_81B3, 32'h4, 0, 0);
    cycle("beq", 1, 32'hFE00_0EE3, 32'h8, 0, 0);
    check_eq("sub.op", 64'(bus.out_op), 64'(OP_SUB));
    check_eq("sub.use_imm", 64'(bus.out_use_imm), 64'd0);
    cycle("pop_sub", 0, 32'h0, 32'h0, 1, 0);
    check_eq("beq.op", 64'(bus.out_op), 64'(OP_BEQ));
    check_eq("beq.branch", 64'(bus.out_branch), 64'd1);
    check_eq("beq.imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
    cycle("drain1", 0, 32'h0, 32'h0, 1, 0);

    // Fill to full, fifth push refused, then simultaneous push+pop while full
    for (int i = 0; i < 5; i++)
      cycle("fill", 1, 32'h0000_0013 | (32'(i + 1) << 7), 32'(16 * i), 0, 0);
    check_eq("full.count", 64'(count), 64'd4);
    check_eq("full.in_ready", 64'(bus.in_ready), 64'd0);
    cycle("full_pop", 1, 32'h0000_0F93, 32'h200, 1, 0);
    check_eq("full_pop.count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) cycle("drain2", 0, 32'h0, 32'h0, 1, 0);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle("pre_flush", 1, rand_inst(), 32'(4 * i), 0, 0);
    cycle("flush", 1, 32'hFFF0_0093, 32'h40, 1, 1);
    check_eq("flush.count", 64'(count), 64'd0);
    check_eq("flush.out_valid", 64'(bus.out_valid), 64'd0);

    // Illegal encodings
    cycle("ill_opc", 1, 32'h0000_007F, 32'h50, 0, 0);
    check_eq("ill_opc.illegal", 64'(bus.out_illegal), 64'd1);
    check_eq("ill_opc.op", 64'(bus.out_op), 64'(OP_ADD));
    cycle("ill_f7", 1, 32'h4000_C0B3, 32'h54, 1, 0);
    check_eq("ill_f7.illegal", 64'(bus.out_illegal), 64'd1);
    cycle("drain3", 0, 32'h0, 32'h0, 1, 0);

`ifdef BR_TARGET_EN
    cycle("jal", 1, 32'h0080_00EF, 32'h100, 0, 0);
    check_eq("jal.imm", 64'(bus.out_imm), 64'd8);
    check_eq("jal.target", 64'(bus.out_target), 64'h108);
    cycle("drain4", 0, 32'h0, 32'h0, 1, 0);
`endif

    // Asynchronous reset mid-stream
    cycle("pre_rst", 1, rand_inst(), 32'h60, 0, 0);
    cycle("pre_rst", 1, rand_inst(), 32'h64, 0, 0);
    bus.in_valid = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    check_eq("arst.out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst.count", 64'(count), 64'd0);
    mq.delete();
    #1 rst_in = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle("rand", $urandom_range(0, 3) != 0, rand_inst(),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
